// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction sequencer.
// Fetches one instruction word through a ready/valid handshake, decodes it
// and walks one to three execute states that steer the datapath muxes,
// register-file ports and write strobes.
module control_fsm #(
    parameter int IW     = 20,
    parameter int RA     = 4,
    parameter int IMM    = 12,
    parameter int JW     = 6,
    parameter bit JZ_POL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           z,
    input  logic           instr_valid,
    input  logic [IW-1:0]  instr,
    output logic           instr_ready,
    output logic [1:0]     alu_op,
    output logic [1:0]     m1,
    output logic           m2,
    output logic [1:0]     m3,
    output logic           m4,
    output logic [RA-1:0]  rpa,
    output logic [RA-1:0]  rpb,
    output logic [RA-1:0]  wpn,
    output logic           reg_we,
    output logic           rst_en,
    output logic           dram_we,
    output logic [IMM-1:0] alpha,
    output logic [JW-1:0]  gamma,
    output logic           busy,
    output logic           illegal
);

    typedef enum logic [2:0] {
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_EX1,
        S_EX2,
        S_EX3
    } state_e;

    typedef enum logic [3:0] {
        OP_RST   = 4'h2,
        OP_WRITE = 4'h3,
        OP_LOADI = 4'h4,
        OP_MUL   = 4'h5,
        OP_LOAD  = 4'h6,
        OP_MV    = 4'h7,
        OP_ADD   = 4'h8,
        OP_INC   = 4'h9,
        OP_SUB   = 4'hA,
        OP_JMPZ  = 4'hB,
        OP_JMP   = 4'hC,
        OP_STORE = 4'hD
    } opcode_e;

    state_e        state, next_state;
    logic [IW-1:0] ir;

    // Last driven values of the outputs that hold between instructions.
    logic [RA-1:0]  rpa_q, rpb_q, wpn_q;
    logic [IMM-1:0] alpha_q;
    logic [JW-1:0]  gamma_q;

    // Instruction fields, always taken from the latched IR.
    opcode_e        opcode;
    logic [RA-1:0]  rd, rs;
    logic [IMM-1:0] imm;
    logic [JW-1:0]  target;
    logic           known_op, needs_ex2, needs_ex3;

    assign opcode = opcode_e'(ir[IW-1 -: 4]);
    assign rd     = ir[IW-5 -: RA];
    assign rs     = ir[IW-5-RA -: RA];
    assign imm    = ir[IMM-1:0];
    assign target = ir[IW-5 -: JW];

    assign known_op  = (ir[IW-1 -: 4] >= 4'h2) && (ir[IW-1 -: 4] <= 4'hD);
    assign needs_ex2 = (opcode == OP_INC) || (opcode == OP_STORE) ||
                       (opcode == OP_LOADI) || (opcode == OP_LOAD);
    assign needs_ex3 = (opcode == OP_LOADI) || (opcode == OP_LOAD);

    // State, IR and held-output registers; IR loads only on the fetch handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH1;
            ir      <= '0;
            rpa_q   <= '0;
            rpb_q   <= '0;
            wpn_q   <= '0;
            alpha_q <= '0;
            gamma_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= next_state;
            rpa_q   <= rpa;
            rpb_q   <= rpb;
            wpn_q   <= wpn;
            alpha_q <= alpha;
            gamma_q <= gamma;
            if (state == S_FETCH1 && instr_valid) begin
                ir <= instr;
            end
        end
    end

    // Next-state and Moore/Mealy outputs for the current state and IR.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state  = state;
        instr_ready = 1'b0;
        alu_op      = 2'b00;
        m1          = 2'b00;
        m2          = 1'b0;
        m3          = 2'b00;
        m4          = 1'b0;
        reg_we      = 1'b0;
        rst_en      = 1'b0;
        dram_we     = 1'b0;
        illegal     = 1'b0;
        rpa         = rpa_q;
        rpb         = rpb_q;
        wpn         = wpn_q;
        alpha       = alpha_q;
        gamma       = gamma_q;
        busy        = (state != S_FETCH1);

        case (state)
            S_FETCH1: begin
                instr_ready = 1'b1;
                if (instr_valid) next_state = S_FETCH2;
            end
            S_FETCH2: begin
                m3         = 2'b01;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                if (known_op) begin
                    next_state = S_EX1;
                end else begin
                    illegal    = 1'b1;
                    m3         = 2'b11;
                    next_state = S_FETCH1;
                end
            end
            S_EX1: begin
                next_state = needs_ex2 ? S_EX2 : S_FETCH1;
                case (opcode)
                    OP_RST:   begin rst_en = 1'b1; wpn = rd; end
                    OP_WRITE: begin reg_we = 1'b1; wpn = rd; m1 = 2'b00; alpha = imm; end
                    OP_ADD:   begin alu_op = 2'b01; rpa = rd; rpb = rs; end
                    OP_SUB:   begin alu_op = 2'b10; rpa = rd; rpb = rs; end
                    OP_MUL:   begin alu_op = 2'b11; rpa = rd; rpb = rs; end
                    OP_MV:    begin m1 = 2'b11; wpn = rd; reg_we = 1'b1; end
                    OP_INC:   begin rpa = rd; rpb = '1; alu_op = 2'b01; end
                    OP_LOADI: begin alpha = imm; m4 = 1'b0; end
                    OP_LOAD:  begin m4 = 1'b1; rpa = rd; end
                    OP_STORE: begin m4 = 1'b1; rpa = rs; end
                    OP_JMP:   begin gamma = target; m3 = 2'b10; end
                    OP_JMPZ: begin
                        if (z == JZ_POL) begin
                            gamma = target;
                            m3    = 2'b10;
                        end
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                next_state = needs_ex3 ? S_EX3 : S_FETCH1;
                case (opcode)
                    OP_INC:   begin m1 = 2'b11; wpn = rd; reg_we = 1'b1; end
                    OP_LOADI: m2 = 1'b1;
                    OP_LOAD:  m2 = 1'b1;
                    OP_STORE: begin rpb = rd; m2 = 1'b0; dram_we = 1'b1; end
                    default: ;
                endcase
            end
            S_EX3: begin
                next_state = S_FETCH1;
                case (opcode)
                    OP_LOADI: begin m1 = 2'b01; wpn = rd; reg_we = 1'b1; end
                    OP_LOAD:  begin m1 = 2'b01; wpn = rs; reg_we = 1'b1; end
                    default: ;
                endcase
            end
            default: next_state = S_FETCH1;
        endcase
    end

endmodule
